// File: rtl/vending_pkg.sv
// Shared types and tables for the coffee vending sequencer: FSM states, drink
// indices, serving-stage codes, per-drink cost and recipe tables.
package vending_pkg;

    localparam int CREDIT_W = 5;
    localparam int MAX_STEPS = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAY,
        ST_SERVE,
        ST_CHANGE,
        ST_DONE
    } fsm_t;

    // Index matches the button bit position.
    typedef enum logic [1:0] {
        DRK_EXPRESSO  = 2'd0,
        DRK_C_LECHE   = 2'd1,
        DRK_CAPUCCINO = 2'd2,
        DRK_MOCACCINO = 2'd3
    } drink_t;

    localparam logic [3:0] STG_NONE   = 4'b0000;
    localparam logic [3:0] STG_CAFE   = 4'b0001;
    localparam logic [3:0] STG_LECHE  = 4'b0010;
    localparam logic [3:0] STG_CHOCO  = 4'b0100;
    localparam logic [3:0] STG_ESPUMA = 4'b1000;

    typedef struct packed {
        logic [3:0] code;
        logic [3:0] dur;
    } step_t;

    function automatic logic [2:0] drink_cost(input drink_t d);
        logic [2:0] c;
        case (d)
            DRK_EXPRESSO:  c = 3'd4;
            DRK_C_LECHE:   c = 3'd5;
            DRK_CAPUCCINO: c = 3'd6;
            default:       c = 3'd7;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] recipe_len(input drink_t d);
        logic [1:0] n;
        case (d)
            DRK_EXPRESSO: n = 2'd1;
            DRK_C_LECHE:  n = 2'd2;
            default:      n = 2'd3;
        endcase
        return n;
    endfunction

    function automatic step_t recipe_step(input drink_t d, input logic [1:0] idx);
        step_t s;
        s = '{code: STG_NONE, dur: 4'd0};
        case (d)
            DRK_EXPRESSO: begin
                if (idx == 2'd0) s = '{code: STG_CAFE, dur: 4'd3};
            end
            DRK_C_LECHE: begin
                case (idx)
                    2'd0:    s = '{code: STG_CAFE,  dur: 4'd3};
                    2'd1:    s = '{code: STG_LECHE, dur: 4'd4};
                    default: s = '{code: STG_NONE,  dur: 4'd0};
                endcase
            end
            DRK_CAPUCCINO: begin
                case (idx)
                    2'd0:    s = '{code: STG_CAFE,   dur: 4'd3};
                    2'd1:    s = '{code: STG_LECHE,  dur: 4'd2};
                    2'd2:    s = '{code: STG_ESPUMA, dur: 4'd3};
                    default: s = '{code: STG_NONE,   dur: 4'd0};
                endcase
            end
            default: begin
                case (idx)
                    2'd0:    s = '{code: STG_CAFE,  dur: 4'd3};
                    2'd1:    s = '{code: STG_CHOCO, dur: 4'd2};
                    2'd2:    s = '{code: STG_LECHE, dur: 4'd3};
                    default: s = '{code: STG_NONE,  dur: 4'd0};
                endcase
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/credit_accumulator.sv
// Coin credit register: adds accepted coins, refuses coins that would overflow
// CREDIT_MAX or arrive while closed, and zeroes on clear/refund.
module credit_accumulator
    import vending_pkg::*;
#(
    parameter int CREDIT_MAX = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_en,
    input  logic                moneda100,
    input  logic                moneda500,
    input  logic                clear,
    input  logic                refund,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_accepted,
    output logic                coin_reject
);

    logic [CREDIT_W:0] coin_add;
    logic [CREDIT_W:0] credit_sum;
    logic              coin_any;
    logic              coin_fits;

    always_comb begin
        coin_add      = (CREDIT_W+1)'(moneda100) + (moneda500 ? (CREDIT_W+1)'(5) : '0);
        credit_sum    = {1'b0, credit} + coin_add;
        coin_any      = moneda100 | moneda500;
        coin_fits     = credit_sum <= (CREDIT_W+1)'(CREDIT_MAX);
        coin_accepted = coin_any && coin_en && coin_fits;
    end

    // A coin landing in the same cycle as a clear or refund is lost, so flag it.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit      <= '0;
            coin_reject <= 1'b0;
        end else begin
            coin_reject <= coin_any && !(coin_accepted && !clear && !refund);
            if (clear || refund)
                credit <= '0;
            else if (coin_accepted)
                credit <= credit_sum[CREDIT_W-1:0];
        end
    end

endmodule

// File: rtl/vending_sequencer.sv
// Main control FSM of the coffee vending machine: drink selection, payment,
// timed ingredient stages on the 1 Hz tick, and change issue.
module vending_sequencer
    import vending_pkg::*;
#(
    parameter int CREDIT_MAX  = 20,
    parameter int PAY_TIMEOUT = 15,
    parameter int DONE_HOLD   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [3:0]          btn,
    input  logic                cancel,
    input  logic                moneda100,
    input  logic                moneda500,
    output logic [3:0]          sel,
    output logic [2:0]          cost,
    output logic [CREDIT_W-1:0] credit,
    output logic [3:0]          state,
    output logic [3:0]          time_left,
    output logic [CREDIT_W-1:0] change,
    output logic                change_valid,
    output logic                coin_reject,
    output logic                busy
);

    localparam int CNT_MAX = (PAY_TIMEOUT > DONE_HOLD) ? PAY_TIMEOUT : DONE_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    fsm_t             fsm, fsm_nxt;
    drink_t           drink;
    logic [1:0]       step_idx;
    logic [CNT_W-1:0] tick_cnt;

    logic [3:0] btn_pressed;
    logic       btn_single;
    drink_t     btn_drink;
    step_t      first_step, next_step;
    logic       coin_en, coin_accepted, pay_timeout, paid, last_sec;
    logic       do_latch, do_refund, do_serve_start, do_step, do_serve_end;
    logic       do_change, do_done_exit;

    credit_accumulator #(
        .CREDIT_MAX(CREDIT_MAX)
    ) u_credit (
        .clk          (clk),
        .rst          (rst),
        .coin_en      (coin_en),
        .moneda100    (moneda100),
        .moneda500    (moneda500),
        .clear        (do_change),
        .refund       (do_refund),
        .credit       (credit),
        .coin_accepted(coin_accepted),
        .coin_reject  (coin_reject)
    );

    // Buttons are active-low; only a single pressed button names a drink.
    always_comb begin
        btn_pressed = ~btn;
        btn_single  = 1'b1;
        btn_drink   = DRK_EXPRESSO;
        case (btn_pressed)
            4'b0001: btn_drink = DRK_EXPRESSO;
            4'b0010: btn_drink = DRK_C_LECHE;
            4'b0100: btn_drink = DRK_CAPUCCINO;
            4'b1000: btn_drink = DRK_MOCACCINO;
            default: btn_single = 1'b0;
        endcase
    end

    always_comb begin
        first_step  = recipe_step(drink, 2'd0);
        next_step   = recipe_step(drink, step_idx + 2'd1);
        coin_en     = (fsm == ST_IDLE) || (fsm == ST_PAY);
        paid        = credit >= {2'b00, cost};
        last_sec    = tick && (time_left == 4'd1);
        pay_timeout = tick && !coin_accepted && (tick_cnt == CNT_W'(PAY_TIMEOUT - 1));
        busy        = (fsm == ST_SERVE) || (fsm == ST_CHANGE) || (fsm == ST_DONE);
    end

    always_comb begin
        fsm_nxt        = fsm;
        do_latch       = 1'b0;
        do_refund      = 1'b0;
        do_serve_start = 1'b0;
        do_step        = 1'b0;
        do_serve_end   = 1'b0;
        do_change      = 1'b0;
        do_done_exit   = 1'b0;
        case (fsm)
            ST_IDLE: begin
                if (cancel && (credit != '0)) begin
                    do_refund = 1'b1;
                end else if (btn_single) begin
                    do_latch = 1'b1;
                    fsm_nxt  = ST_PAY;
                end
            end
            ST_PAY: begin
                if (cancel || pay_timeout) begin
                    do_refund = 1'b1;
                    fsm_nxt   = ST_IDLE;
                end else if (paid) begin
                    do_serve_start = 1'b1;
                    fsm_nxt        = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (last_sec) begin
                    if ((step_idx + 2'd1) < recipe_len(drink)) begin
                        do_step = 1'b1;
                    end else begin
                        do_serve_end = 1'b1;
                        fsm_nxt      = ST_CHANGE;
                    end
                end
            end
            ST_CHANGE: begin
                do_change = 1'b1;
                fsm_nxt   = ST_DONE;
            end
            ST_DONE: begin
                if (tick && (tick_cnt == CNT_W'(DONE_HOLD - 1))) begin
                    do_done_exit = 1'b1;
                    fsm_nxt      = ST_IDLE;
                end
            end
            default: fsm_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm          <= ST_IDLE;
            drink        <= DRK_EXPRESSO;
            step_idx     <= 2'd0;
            tick_cnt     <= '0;
            sel          <= 4'd0;
            cost         <= 3'd0;
            state        <= STG_NONE;
            time_left    <= 4'd0;
            change       <= '0;
            change_valid <= 1'b0;
        end else begin
            fsm          <= fsm_nxt;
            change_valid <= 1'b0;

            if (do_latch) begin
                drink <= btn_drink;
                sel   <= 4'(4'b0001 << btn_drink);
                cost  <= drink_cost(btn_drink);
            end

            if (do_refund) begin
                change       <= credit;
                change_valid <= 1'b1;
                sel          <= 4'd0;
                cost         <= 3'd0;
            end else if (do_change) begin
                change       <= credit - {2'b00, cost};
                change_valid <= 1'b1;
            end

            if (do_done_exit) begin
                sel  <= 4'd0;
                cost <= 3'd0;
            end

            // Stage stepping: load on entry to each stage, count down on tick.
            if (do_serve_start) begin
                step_idx  <= 2'd0;
                state     <= first_step.code;
                time_left <= first_step.dur;
            end else if (do_step) begin
                step_idx  <= step_idx + 2'd1;
                state     <= next_step.code;
                time_left <= next_step.dur;
            end else if (do_serve_end) begin
                step_idx  <= 2'd0;
                state     <= STG_NONE;
                time_left <= 4'd0;
            end else if ((fsm == ST_SERVE) && tick) begin
                time_left <= time_left - 4'd1;
            end

            // One tick counter serves both the PAY idle timer and the DONE hold.
            if (fsm_nxt != fsm)
                tick_cnt <= '0;
            else if ((fsm == ST_PAY) && coin_accepted)
                tick_cnt <= '0;
            else if (tick && ((fsm == ST_PAY) || (fsm == ST_DONE)))
                tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_vending_sequencer.sv
// Self-checking bench for vending_sequencer: directed scenarios plus randomized
// purchases compared against a transaction-level model of the machine.
module tb_vending_sequencer;

    logic       clk = 1'b0;
    logic       rst, tick, cancel, moneda100, moneda500;
    logic [3:0] btn;
    logic [3:0] sel, state, time_left;
    logic [2:0] cost;
    logic [4:0] credit, change;
    logic       change_valid, coin_reject, busy;

    int n_cmp = 0;
    int n_err = 0;

    // Drink model taken from the price list and recipes.
    int         cost_tab[4] = '{4, 5, 6, 7};
    int         rec_n[4]    = '{1, 2, 3, 3};
    logic [3:0] rec_code[4][3] = '{'{4'b0001, 4'b0000, 4'b0000},
                                   '{4'b0001, 4'b0010, 4'b0000},
                                   '{4'b0001, 4'b0010, 4'b1000},
                                   '{4'b0001, 4'b0100, 4'b0010}};
    int         rec_dur[4][3]  = '{'{3, 0, 0}, '{3, 4, 0}, '{3, 2, 3}, '{3, 2, 3}};

    int mc;         // model credit
    int pay_ticks;  // ticks since PAY entry or last accepted coin
    int last_change;

    vending_sequencer dut (
        .clk(clk), .rst(rst), .tick(tick), .btn(btn), .cancel(cancel),
        .moneda100(moneda100), .moneda500(moneda500), .sel(sel), .cost(cost),
        .credit(credit), .state(state), .time_left(time_left), .change(change),
        .change_valid(change_valid), .coin_reject(coin_reject), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic press(input int d);
        btn = ~(4'b0001 << d);
        cyc();
        btn = 4'hF;
        chk("sel_latch", sel, 32'(1 << d));
        chk("cost_latch", cost, cost_tab[d]);
        pay_ticks = 0;
    endtask

    task automatic coin(input bit c100, input bit c500, input bit open);
        int add;
        bit rej;
        add = (c100 ? 1 : 0) + (c500 ? 5 : 0);
        rej = !open || (mc + add > 20);
        if (!rej) begin
            mc = mc + add;
            pay_ticks = 0;
        end
        moneda100 = c100;
        moneda500 = c500;
        cyc();
        moneda100 = 1'b0;
        moneda500 = 1'b0;
        chk("credit", credit, mc);
        chk("coin_reject", coin_reject, rej);
    endtask

    task automatic refund_check(input string tag);
        chk({tag, "_cv"}, change_valid, 1);
        chk({tag, "_change"}, change, mc);
        chk({tag, "_credit"}, credit, 0);
        chk({tag, "_sel"}, sel, 0);
        chk({tag, "_busy"}, busy, 0);
        last_change = mc;
        mc = 0;
    endtask

    // Credit already covers the cost: the next edge leaves PAY.
    task automatic serve(input int d);
        int r;
        cyc();
        for (int s = 0; s < rec_n[d]; s++) begin
            for (int k = 0; k < rec_dur[d][s]; k++) begin
                r = (s == 0 && k == 0) ? 1 : int'($urandom_range(0, 3));
                if (r == 0) begin
                    cancel = 1'b1;
                    cyc();
                    cancel = 1'b0;
                end else if (r == 1) begin
                    coin(1'b1, 1'b0, 1'b0);
                end
                chk("stage", state, rec_code[d][s]);
                chk("time_left", time_left, rec_dur[d][s] - k);
                chk("busy_serve", busy, 1);
                pulse_tick();
            end
        end
        chk("stage_cleared", state, 0);
        chk("cv_before_change", change_valid, 0);
        cyc();
        chk("change_valid", change_valid, 1);
        chk("change", change, mc - cost_tab[d]);
        chk("credit_cleared", credit, 0);
        last_change = mc - cost_tab[d];
        mc = 0;
        cyc();
        chk("cv_pulse_end", change_valid, 0);
        chk("change_hold", change, last_change);
        pulse_tick();
        chk("busy_done", busy, 1);
        chk("sel_done", sel, 32'(1 << d));
        pulse_tick();
        chk("busy_idle", busy, 0);
        chk("sel_cleared", sel, 0);
        chk("cost_cleared", cost, 0);
    endtask

    task automatic pay_random(input int d);
        int r;
        while (mc < cost_tab[d]) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                pulse_tick();
                pay_ticks++;
            end
            r = $urandom_range(0, 2);
            coin(r != 1, r != 0, 1'b1);
        end
    endtask

    task automatic pay_partial(input int d);
        int n;
        n = $urandom_range(0, cost_tab[d] - 1);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                pulse_tick();
                pay_ticks++;
            end
            coin(1'b1, 1'b0, 1'b1);
        end
    endtask

    task automatic run_timeout(input int d);
        while (pay_ticks < 14) begin
            pulse_tick();
            pay_ticks++;
        end
        chk("pre_timeout_cv", change_valid, 0);
        chk("pre_timeout_sel", sel, 32'(1 << d));
        pulse_tick();
        refund_check("timeout");
    endtask

    initial begin
        int d, kind;
        rst = 1'b1; tick = 1'b0; cancel = 1'b0; moneda100 = 1'b0; moneda500 = 1'b0;
        btn = 4'hF; mc = 0; pay_ticks = 0; last_change = 0;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_sel", sel, 0);
        chk("rst_cost", cost, 0);
        chk("rst_credit", credit, 0);
        chk("rst_state", state, 0);
        chk("rst_time_left", time_left, 0);
        chk("rst_change", change, 0);
        chk("rst_cv", change_valid, 0);
        chk("rst_reject", coin_reject, 0);
        chk("rst_busy", busy, 0);

        // Expresso paid with four 100 coins.
        press(0);
        for (int i = 0; i < 4; i++) coin(1'b1, 1'b0, 1'b1);
        serve(0);

        // Capuccino paid with both coins in one cycle.
        press(2);
        coin(1'b1, 1'b1, 1'b1);
        serve(2);

        // Mocaccino overpaid: change of 3.
        press(3);
        coin(1'b0, 1'b1, 1'b1);
        coin(1'b0, 1'b1, 1'b1);
        serve(3);

        // C_leche abandoned: timeout, then cancel.
        press(1);
        coin(1'b1, 1'b0, 1'b1);
        run_timeout(1);
        press(1);
        coin(1'b1, 1'b0, 1'b1);
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        refund_check("cancel_pay");

        // Credit ceiling, then refund from IDLE.
        for (int i = 0; i < 19; i++) coin(1'b1, 1'b0, 1'b1);
        coin(1'b0, 1'b1, 1'b1);
        coin(1'b1, 1'b1, 1'b1);
        coin(1'b1, 1'b0, 1'b1);
        coin(1'b1, 1'b0, 1'b1);
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        refund_check("cancel_idle");

        // Credit inserted before choosing: PAY lasts a single cycle.
        coin(1'b0, 1'b1, 1'b1);
        press(0);
        serve(0);

        // Randomized purchases.
        for (int t = 0; t < 10; t++) begin
            d = $urandom_range(0, 3);
            kind = $urandom_range(0, 3);
            press(d);
            if (kind <= 1) begin
                pay_random(d);
                serve(d);
            end else if (kind == 2) begin
                pay_partial(d);
                cancel = 1'b1;
                cyc();
                cancel = 1'b0;
                refund_check("rand_cancel");
            end else begin
                pay_partial(d);
                run_timeout(d);
            end
        end

        // Reset in the middle of serving.
        press(0);
        for (int i = 0; i < 4; i++) coin(1'b1, 1'b0, 1'b1);
        cyc();
        pulse_tick();
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        mc = 0;
        chk("mid_rst_sel", sel, 0);
        chk("mid_rst_cost", cost, 0);
        chk("mid_rst_credit", credit, 0);
        chk("mid_rst_state", state, 0);
        chk("mid_rst_time_left", time_left, 0);
        chk("mid_rst_change", change, 0);
        chk("mid_rst_cv", change_valid, 0);
        chk("mid_rst_busy", busy, 0);

        // Two buttons at once are ignored; a single press still latches.
        btn = 4'b1100;
        cyc();
        btn = 4'hF;
        chk("multi_btn_sel", sel, 0);
        chk("multi_btn_cost", cost, 0);
        press(1);
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        refund_check("cancel_empty");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
